// File: rtl/st_serializer.sv
// st_serializer: accepts one typed, variable-length message per handshake and
// emits it as a WIDTH-bit streaming packet with sop/eop/len framing and full
// valid/ready backpressure. Messages of the wrong type or with an out-of-range
// byte count are consumed and counted in a saturating drop counter.
module st_serializer #(
   parameter int WIDTH     = 32,
   parameter int MAX_BYTES = 16,
   parameter int TYPE_W    = 8,
   parameter int MSG_TYPE  = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_msg_valid,
   output logic                           i_msg_ready,
   input  logic [TYPE_W-1:0]              i_msg_type,
   input  logic [$clog2(MAX_BYTES+1)-1:0] i_msg_nbytes,
   input  logic [MAX_BYTES*8-1:0]         i_msg_payload,
   output logic                           o_pkt_valid,
   input  logic                           o_pkt_ready,
   output logic                           o_pkt_sop,
   output logic                           o_pkt_eop,
   output logic [$clog2(WIDTH/8)-1:0]     o_pkt_len,
   output logic [WIDTH-1:0]               o_pkt_data,
   output logic [15:0]                    o_drop_cnt
);

   localparam int BPB       = WIDTH / 8;
   localparam int LEN_W     = $clog2(BPB);
   localparam int MAX_BEATS = (MAX_BYTES + BPB - 1) / BPB;
   localparam int IDX_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int PAD_W     = MAX_BEATS * WIDTH;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] last_idx_q;
   logic [LEN_W-1:0] tail_len_q;
   logic [PAD_W-1:0] pad_q;

   logic             pkt_valid_q;
   logic             pkt_sop_q;
   logic             pkt_eop_q;
   logic [LEN_W-1:0] pkt_len_q;
   logic [WIDTH-1:0] pkt_data_q;
   logic [15:0]      drop_cnt_q;

   logic [PAD_W-1:0] pad_d;
   logic [IDX_W-1:0] last_idx_d;
   logic [IDX_W-1:0] nxt_idx_d;
   logic [WIDTH-1:0] nxt_data_d;
   logic             msg_ok_d;
   logic             msg_hs_d;

   // Ready only in IDLE and never while reset is asserted, so reset wins over
   // a simultaneous handshake.
   assign i_msg_ready = rst_n && (state_q == IDLE);
   assign msg_hs_d    = i_msg_valid && i_msg_ready;

   assign o_pkt_valid = pkt_valid_q;
   assign o_pkt_sop   = pkt_sop_q;
   assign o_pkt_eop   = pkt_eop_q;
   assign o_pkt_len   = pkt_len_q;
   assign o_pkt_data  = pkt_data_q;
   assign o_drop_cnt  = drop_cnt_q;

   // Decode the offered message: validity, beat count, and the payload with
   // bytes beyond nbytes zeroed and padded out to a whole number of beats.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      pad_d      = '0;
      msg_ok_d   = (i_msg_type == TYPE_W'(MSG_TYPE)) &&
                   (i_msg_nbytes != '0) &&
                   (int'(i_msg_nbytes) <= MAX_BYTES);
      last_idx_d = IDX_W'((int'(i_msg_nbytes) + BPB - 1) / BPB - 1);
      for (int k = 0; k < MAX_BYTES; k++) begin
         if (k < int'(i_msg_nbytes)) begin
            pad_d[8*k +: 8] = i_msg_payload[8*k +: 8];
         end
      end
   end

   // Next beat selection while a packet is in flight.
   always_comb begin
      nxt_idx_d  = idx_q + 1'b1;
      nxt_data_d = pad_q[int'(nxt_idx_d)*WIDTH +: WIDTH];
   end

   // Payload store: loaded on an accepted message, read only in SEND.
   // NOTE: this wide data register carries no reset; its contents are never
   // observed until a handshake has overwritten them.
   always_ff @(posedge clk) begin
      if (msg_hs_d && msg_ok_d) begin
         pad_q <= pad_d;
      end
   end

   // Control FSM with registered packet outputs and the drop counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of its peers.
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         last_idx_q  <= '0;
         tail_len_q  <= '0;
         pkt_valid_q <= 1'b0;
         pkt_sop_q   <= 1'b0;
         pkt_eop_q   <= 1'b0;
         pkt_len_q   <= '0;
         pkt_data_q  <= '0;
         drop_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (msg_hs_d) begin
                  if (msg_ok_d) begin
                     state_q     <= SEND;
                     idx_q       <= '0;
                     last_idx_q  <= last_idx_d;
                     tail_len_q  <= i_msg_nbytes[LEN_W-1:0];
                     pkt_valid_q <= 1'b1;
                     pkt_sop_q   <= 1'b1;
                     pkt_eop_q   <= (last_idx_d == '0);
                     pkt_len_q   <= (last_idx_d == '0) ? i_msg_nbytes[LEN_W-1:0] : '0;
                     pkt_data_q  <= pad_d[WIDTH-1:0];
                  end else if (drop_cnt_q != 16'hFFFF) begin
                     drop_cnt_q <= drop_cnt_q + 16'd1;
                  end
               end
            end
            SEND: begin
               // Outputs only move on an accepted beat, so a stalled sink sees
               // them held stable.
               if (o_pkt_ready) begin
                  if (pkt_eop_q) begin
                     state_q     <= IDLE;
                     pkt_valid_q <= 1'b0;
                     pkt_sop_q   <= 1'b0;
                     pkt_eop_q   <= 1'b0;
                     pkt_len_q   <= '0;
                     pkt_data_q  <= '0;
                  end else begin
                     idx_q      <= nxt_idx_d;
                     pkt_sop_q  <= 1'b0;
                     pkt_eop_q  <= (nxt_idx_d == last_idx_q);
                     pkt_len_q  <= (nxt_idx_d == last_idx_q) ? tail_len_q : '0;
                     pkt_data_q <= nxt_data_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_st_serializer.sv
// Directed testbench for st_serializer (WIDTH=32, MAX_BYTES=16, MSG_TYPE=3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_st_serializer;

   logic         clk;
   logic         rst_n;
   logic         i_msg_valid;
   logic         i_msg_ready;
   logic [7:0]   i_msg_type;
   logic [4:0]   i_msg_nbytes;
   logic [127:0] i_msg_payload;
   logic         o_pkt_valid;
   logic         o_pkt_ready;
   logic         o_pkt_sop;
   logic         o_pkt_eop;
   logic [1:0]   o_pkt_len;
   logic [31:0]  o_pkt_data;
   logic [15:0]  o_drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_drop = 0;

   typedef struct {
      logic [7:0]       typ;
      logic [4:0]       nb;
      logic [127:0]     pl;
      int               nbeats;   // 0 means the message must be dropped
      logic [3:0][31:0] data;
      logic [1:0]       len;
   } vec_t;

   vec_t vecs[8];

   st_serializer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_msg_valid   (i_msg_valid),
      .i_msg_ready   (i_msg_ready),
      .i_msg_type    (i_msg_type),
      .i_msg_nbytes  (i_msg_nbytes),
      .i_msg_payload (i_msg_payload),
      .o_pkt_valid   (o_pkt_valid),
      .o_pkt_ready   (o_pkt_ready),
      .o_pkt_sop     (o_pkt_sop),
      .o_pkt_eop     (o_pkt_eop),
      .o_pkt_len     (o_pkt_len),
      .o_pkt_data    (o_pkt_data),
      .o_drop_cnt    (o_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [7:0] typ, input logic [4:0] nb,
                          input logic [127:0] pl, input int nbeats,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [1:0] len);
      vecs[i].typ    = typ;
      vecs[i].nb     = nb;
      vecs[i].pl     = pl;
      vecs[i].nbeats = nbeats;
      vecs[i].data   = {d3, d2, d1, d0};
      vecs[i].len    = len;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " valid"}, 32'(o_pkt_valid), 32'd0);
      check({tag, " data"},  o_pkt_data, 32'd0);
      check({tag, " sop"},   32'(o_pkt_sop), 32'd0);
      check({tag, " eop"},   32'(o_pkt_eop), 32'd0);
      check({tag, " len"},   32'(o_pkt_len), 32'd0);
      check({tag, " ready"}, 32'(i_msg_ready), 32'd1);
   endtask

   // Offers one message; returns at the falling edge right after the handshake,
   // where the first beat (or the drop) must already be visible.
   task automatic offer(input logic [7:0] typ, input logic [4:0] nb, input logic [127:0] pl);
      @(negedge clk);
      i_msg_valid   = 1'b1;
      i_msg_type    = typ;
      i_msg_nbytes  = nb;
      i_msg_payload = pl;
      check("ready before accept", 32'(i_msg_ready), 32'd1);
      @(negedge clk);
      i_msg_valid   = 1'b0;
      i_msg_type    = $urandom_range(255, 0);
      i_msg_nbytes  = 5'($urandom_range(31, 0));
      i_msg_payload = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic check_beat(input string tag, input logic [31:0] data, input logic sop,
                             input logic eop, input logic [1:0] len);
      check({tag, " valid"}, 32'(o_pkt_valid), 32'd1);
      check({tag, " data"},  o_pkt_data, data);
      check({tag, " sop"},   32'(o_pkt_sop), 32'(sop));
      check({tag, " eop"},   32'(o_pkt_eop), 32'(eop));
      check({tag, " len"},   32'(o_pkt_len), 32'(len));
      check({tag, " ready"}, 32'(i_msg_ready), 32'd0);
   endtask

   task automatic run_vec(input int i);
      string tag;
      offer(vecs[i].typ, vecs[i].nb, vecs[i].pl);
      if (vecs[i].nbeats == 0) begin
         exp_drop++;
         tag = $sformatf("vec%0d drop", i);
         check({tag, " cnt"}, 32'(o_drop_cnt), 32'(exp_drop));
         check_idle(tag);
      end else begin
         for (int b = 0; b < vecs[i].nbeats; b++) begin
            tag = $sformatf("vec%0d beat%0d", i, b);
            check_beat(tag, vecs[i].data[b], b == 0, b == vecs[i].nbeats - 1,
                       (b == vecs[i].nbeats - 1) ? vecs[i].len : 2'd0);
            @(negedge clk);
         end
         tag = $sformatf("vec%0d after eop", i);
         check_idle(tag);
         check({tag, " drop cnt"}, 32'(o_drop_cnt), 32'(exp_drop));
      end
   endtask

   localparam logic [127:0] PL_SEQ = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

   initial begin
      set_vec(0, 8'd3, 5'd15, PL_SEQ, 4,
              32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h000E0D0C, 2'd3);
      set_vec(1, 8'd3, 5'd8, PL_SEQ, 2,
              32'h03020100, 32'h07060504, 32'h0, 32'h0, 2'd0);
      set_vec(2, 8'd3, 5'd1, 128'h55555555_55555555_55555555_555555AA, 1,
              32'h000000AA, 32'h0, 32'h0, 32'h0, 2'd1);
      set_vec(3, 8'd2, 5'd4, PL_SEQ, 0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
      set_vec(4, 8'd3, 5'd0, PL_SEQ, 0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
      set_vec(5, 8'd3, 5'd16, 128'h1F1E1D1C_1B1A1918_17161514_13121110, 4,
              32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C, 2'd0);
      set_vec(6, 8'd3, 5'd17, PL_SEQ, 0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
      set_vec(7, 8'd3, 5'd5, PL_SEQ, 2,
              32'h03020100, 32'h00000004, 32'h0, 32'h0, 2'd1);

      rst_n         = 1'b0;
      i_msg_valid   = 1'b0;
      i_msg_type    = 8'd0;
      i_msg_nbytes  = 5'd0;
      i_msg_payload = '0;
      o_pkt_ready   = 1'b1;

      // Reset state, with a message offered to show reset wins.
      i_msg_valid = 1'b1;
      i_msg_type  = 8'd3;
      i_msg_nbytes = 5'd4;
      repeat (3) @(negedge clk);
      check("reset ready",    32'(i_msg_ready), 32'd0);
      check("reset valid",    32'(o_pkt_valid), 32'd0);
      check("reset data",     o_pkt_data, 32'd0);
      check("reset drop cnt", 32'(o_drop_cnt), 32'd0);
      i_msg_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post reset");

      // Table-driven vectors with the sink always ready.
      for (int i = 0; i < 8; i++) begin
         run_vec(i);
      end

      // Backpressure on beat 1: held for 4 samples, then beats 2 and 3.
      offer(8'd3, 5'd15, PL_SEQ);
      check_beat("bp beat0", 32'h03020100, 1'b1, 1'b0, 2'd0);
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         check_beat($sformatf("bp beat1 hold%0d", s), 32'h07060504, 1'b0, 1'b0, 2'd0);
         o_pkt_ready = (s == 3);
         @(negedge clk);
      end
      check_beat("bp beat2", 32'h0B0A0908, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      check_beat("bp beat3", 32'h000E0D0C, 1'b0, 1'b1, 2'd3);
      @(negedge clk);
      check_idle("bp after eop");

      // Reset asserted during beat 2 aborts the packet.
      offer(8'd3, 5'd15, PL_SEQ);
      check_beat("rst beat0", 32'h03020100, 1'b1, 1'b0, 2'd0);
      @(negedge clk);
      check_beat("rst beat1", 32'h07060504, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      check_beat("rst beat2", 32'h0B0A0908, 1'b0, 1'b0, 2'd0);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid rst valid",    32'(o_pkt_valid), 32'd0);
      check("mid rst data",     o_pkt_data, 32'd0);
      check("mid rst eop",      32'(o_pkt_eop), 32'd0);
      check("mid rst drop cnt", 32'(o_drop_cnt), 32'd0);
      check("mid rst ready",    32'(i_msg_ready), 32'd0);
      rst_n = 1'b1;
      exp_drop = 0;
      @(negedge clk);
      check_idle("after mid rst");
      run_vec(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/st_serializer.md
# st_serializer

Parametrised message-to-packet serializer: accepts one message per handshake, carrying a type code, a runtime byte count and a flat payload, and emits it as a WIDTH-bit streaming packet with sop/eop/len. It is the generalised successor of the fixed-layout single-type encoder. It adds runtime message length, configurable beat width and payload depth, and full valid/ready backpressure on the packet output. It also counts rejected messages. It sits between field-assembly logic and the packet transmit path.

## Interface

- WIDTH, 32, output beat width in bits; multiple of 8, WIDTH/8 a power of two ≥ 2 (BPB = WIDTH/8 bytes per beat)
- MAX_BYTES, 16, largest payload in bytes; ≥ 1
- TYPE_W, 8, message type code width
- MSG_TYPE, 3, the only type code serialized

- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- i_msg_valid  in  1  message offered
- i_msg_ready  out  1  message accepted when valid & ready
- i_msg_type  in  TYPE_W  message type code
- i_msg_nbytes  in  $clog2(MAX_BYTES+1)  payload length in bytes
- i_msg_payload  in  MAX_BYTES*8  byte k at bits [8k+7:8k]
- o_pkt_valid  out  1  beat valid
- o_pkt_ready  in  1  sink accepts beat when valid & ready
- o_pkt_sop  out  1  first beat of packet
- o_pkt_eop  out  1  last beat of packet
- o_pkt_len  out  $clog2(BPB)  valid bytes in eop beat mod BPB (0 = all valid)
- o_pkt_data  out  WIDTH  beat data, lowest-index byte in LSBs
- o_drop_cnt  out  16  rejected messages, saturating

## Operation

- States: IDLE, SEND. Reset → IDLE.
- IDLE: i_msg_ready = 1 (0 while rst_n low); o_pkt_valid = 0.
- On handshake in IDLE:
  - Valid message: type == MSG_TYPE and 1 ≤ nbytes ≤ MAX_BYTES. Register payload and nbytes. Set beats = ceil(nbytes/BPB), beat index = 0. Go to SEND.
  - Otherwise: message consumed and discarded; o_drop_cnt += 1, saturating at 0xFFFF; stay in IDLE.
- SEND: i_msg_ready = 0; o_pkt_valid = 1.
  - o_pkt_data = payload bytes [idx*BPB +: BPB]; bytes at positions ≥ nbytes forced to 0.
  - o_pkt_sop = (idx == 0).
  - o_pkt_eop = (idx == beats-1).
  - o_pkt_len = nbytes mod BPB on the eop beat, else 0.
  - On o_pkt_valid & o_pkt_ready: if eop, go to IDLE; else idx += 1.
  - While o_pkt_ready = 0: all o_pkt_* outputs held stable. No beat is skipped or repeated.
- When o_pkt_valid = 0: o_pkt_data, sop, eop and len are all 0.
- Single-beat packet: sop = eop = 1 on the same beat.
- i_msg_payload and i_msg_type are don't-care outside the handshake cycle.

## Timing

- Reset values: state IDLE, o_pkt_valid/sop/eop = 0, o_pkt_len = 0, o_pkt_data = 0, o_drop_cnt = 0, i_msg_ready = 0 while rst_n low.
- Latency: handshake in cycle t → first beat valid in cycle t+1.
- Throughput with o_pkt_ready held 1: one packet per beats+1 cycles. The IDLE cycle between packets is mandatory; a new message is never accepted in the eop cycle.
- Rejected message: ready remains 1 the next cycle. The counter updates in the cycle after the handshake.
- Reset mid-packet: the packet is aborted with no eop. The cycle after rst_n is sampled low, all outputs are at reset values. The first packet after reset begins with sop.
- Reset has priority over any simultaneous handshake.

## Test plan

- WIDTH=32, nbytes=15, payload bytes 0x00..0x0E, ready=1 → 4 beats 0x03020100 (sop), 0x07060504, 0x0B0A0908, 0x000E0D0C (eop, len=3); first beat in cycle after accept.
- nbytes=8 → 2 beats 0x03020100 (sop), 0x07060504 (eop, len=0); i_msg_ready returns to 1 the cycle after eop handshake.
- nbytes=1, byte 0 = 0xAA → single beat 0x000000AA, sop=eop=1, len=1.
- type=2, then type=3 with nbytes=0 → no output beats, o_drop_cnt 0→1→2, i_msg_ready stays 1.
- 15-byte message, o_pkt_ready low for 3 cycles on beat 1 → 0x07060504 held stable for 4 cycles, then beats 2–3 follow unchanged; exactly 4 beats total.
- rst_n low during beat 2 → next cycle o_pkt_valid=0, data=0, o_drop_cnt=0; after release, next message starts with sop and correct data.
